// File: rtl/pingpong_frame_buf.sv
// pingpong_frame_buf
// Multi-channel ping-pong sample buffer between the I2S receiver and the
// block-processing engine. One bank fills with NUM_CH-channel frames while
// the consumer reads the previously completed block from the other bank.
// A block that completes while the consumer still holds one is dropped and
// its bank refilled; the event raises a one-cycle overflow pulse.
//
// Build option:
//   PINGPONG_OVF_COUNT_EN  defined   -> 16-bit saturating ovf_count register
//                          undefined -> ovf_count tied to 16'h0
module pingpong_frame_buf #(
   parameter int SAMPLE_SIZE = 24,
   parameter int NUM_CH      = 2,
   parameter int CH_BITS     = 1,
   parameter int BLOCK_LEN   = 64,
   parameter int PTR_BITS    = 6
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [CH_BITS-1:0]     in_ch,
   input  logic [SAMPLE_SIZE-1:0] in_sample,
   output logic [PTR_BITS-1:0]    wr_frame,
   output logic                   blk_ready,
   output logic                   blk_bank,
   input  logic                   rd_en,
   input  logic [PTR_BITS-1:0]    rd_frame,
   input  logic [CH_BITS-1:0]     rd_ch,
   output logic [SAMPLE_SIZE-1:0] rd_sample,
   output logic                   rd_valid,
   input  logic                   blk_done,
   output logic                   overflow,
   output logic [15:0]            ovf_count
);

   localparam int DEPTH = 2 * BLOCK_LEN * NUM_CH;
   localparam int AW    = $clog2(DEPTH);

   typedef enum logic {
      IDLE  = 1'b0,
      READY = 1'b1
   } state_t;

   state_t                 state;
   logic                   wr_bank;
   logic [SAMPLE_SIZE-1:0] mem [DEPTH];

   logic          wr_ok;
   logic          frame_end;
   logic          blk_end;
   logic          swap;
   logic          ovf_event;
   logic          rd_ch_ok;
   logic [AW-1:0] wr_idx;
   logic [AW-1:0] rd_idx;

   // Channel indices outside the frame are dropped and never move counters.
   assign wr_ok     = in_valid && (int'(in_ch) < NUM_CH);
   assign frame_end = wr_ok && (int'(in_ch) == NUM_CH - 1);
   assign blk_end   = frame_end && (wr_frame == PTR_BITS'(BLOCK_LEN - 1));

   // A release coinciding with completion frees the consumer first, so the
   // new block swaps in instead of being dropped.
   assign swap      = blk_end && ((state == IDLE) || blk_done);
   assign ovf_event = blk_end && (state == READY) && !blk_done;

   assign rd_ch_ok  = (int'(rd_ch) < NUM_CH);

   // Flat {bank, frame, ch} addressing; works for any NUM_CH/BLOCK_LEN power of two.
   assign wr_idx = AW'(int'(wr_bank) * BLOCK_LEN * NUM_CH + int'(wr_frame) * NUM_CH + int'(in_ch));
   assign rd_idx = AW'(int'(blk_bank) * BLOCK_LEN * NUM_CH + int'(rd_frame) * NUM_CH + int'(rd_ch));

   assign blk_ready = (state == READY);

   // Fill pointer, bank ownership and the consumer FSM.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      if (rst) begin
         state    <= IDLE;
         wr_bank  <= 1'b0;
         blk_bank <= 1'b0;
         wr_frame <= '0;
         overflow <= 1'b0;
      end else begin
         overflow <= ovf_event;
         if (frame_end) begin
            wr_frame <= blk_end ? '0 : wr_frame + 1'b1;
         end
         if (swap) begin
            blk_bank <= wr_bank;
            wr_bank  <= ~wr_bank;
            state    <= READY;
         end else if (blk_done && (state == READY)) begin
            state <= IDLE;
         end
      end
   end

   // Sample storage write port.
   always_ff @(posedge clk) begin
      // NOTE: the sample array has no reset; contents are don't-care until a block completes.
      if (wr_ok && !rst) begin
         mem[wr_idx] <= in_sample;
      end
   end

   // Registered read port, serviced only while the consumer owns a block.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid  <= 1'b0;
         rd_sample <= '0;
      end else if (blk_ready && rd_en) begin
         rd_valid  <= 1'b1;
         rd_sample <= rd_ch_ok ? mem[rd_idx] : '0;
      end else begin
         rd_valid  <= 1'b0;
      end
   end

`ifdef PINGPONG_OVF_COUNT_EN
   logic [15:0] ovf_cnt;

   // Saturating count of dropped blocks, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_cnt <= '0;
      end else if (ovf_event && (ovf_cnt != 16'hFFFF)) begin
         ovf_cnt <= ovf_cnt + 16'd1;
      end
   end

   assign ovf_count = ovf_cnt;
`else
   assign ovf_count = 16'h0;
`endif

endmodule

// File: tb/tb_pingpong_frame_buf.sv
// Testbench for pingpong_frame_buf. Directed steps in one initial block; read
// expectations go into a queue when a read is issued and are compared when
// rd_valid appears. The channel index is 2 bits wide so that out-of-range
// channels (in_ch/rd_ch = 2, 3 with NUM_CH = 2) can be driven.
module tb_pingpong_frame_buf;

   localparam int SS = 24;
   localparam int NC = 2;
   localparam int CB = 2;
   localparam int BL = 64;
   localparam int PB = 6;

`ifdef PINGPONG_OVF_COUNT_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic [CB-1:0] in_ch;
   logic [SS-1:0] in_sample;
   logic [PB-1:0] wr_frame;
   logic          blk_ready;
   logic          blk_bank;
   logic          rd_en;
   logic [PB-1:0] rd_frame;
   logic [CB-1:0] rd_ch;
   logic [SS-1:0] rd_sample;
   logic          rd_valid;
   logic          blk_done;
   logic          overflow;
   logic [15:0]   ovf_count;

   int          checks     = 0;
   int          errors     = 0;
   int          ovf_pulses = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_rd    = '0;

   pingpong_frame_buf #(
      .SAMPLE_SIZE(SS), .NUM_CH(NC), .CH_BITS(CB), .BLOCK_LEN(BL), .PTR_BITS(PB)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ch(in_ch), .in_sample(in_sample),
      .wr_frame(wr_frame), .blk_ready(blk_ready), .blk_bank(blk_bank),
      .rd_en(rd_en), .rd_frame(rd_frame), .rd_ch(rd_ch),
      .rd_sample(rd_sample), .rd_valid(rd_valid),
      .blk_done(blk_done), .overflow(overflow), .ovf_count(ovf_count)
   );

`ifdef PINGPONG_OVF_COUNT_EN
   // Single-sample blocks: every write completes a block, so overflows come
   // one per cycle once the consumer holds the first block.
   logic       sat_in_valid;
   logic       sat_in_ch;
   logic [7:0] sat_in_sample;
   logic       sat_wr_frame;
   logic       sat_blk_ready;
   logic       sat_blk_bank;
   logic [7:0] sat_rd_sample;
   logic       sat_rd_valid;
   logic       sat_overflow;
   logic [15:0] sat_ovf_count;

   pingpong_frame_buf #(
      .SAMPLE_SIZE(8), .NUM_CH(1), .CH_BITS(1), .BLOCK_LEN(1), .PTR_BITS(1)
   ) sat_dut (
      .clk(clk), .rst(rst),
      .in_valid(sat_in_valid), .in_ch(sat_in_ch), .in_sample(sat_in_sample),
      .wr_frame(sat_wr_frame), .blk_ready(sat_blk_ready), .blk_bank(sat_blk_bank),
      .rd_en(1'b0), .rd_frame(1'b0), .rd_ch(1'b0),
      .rd_sample(sat_rd_sample), .rd_valid(sat_rd_valid),
      .blk_done(1'b0), .overflow(sat_overflow), .ovf_count(sat_ovf_count)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Outputs are stable at the falling edge: count overflow pulses and score reads.
   always @(negedge clk) begin
      if (overflow === 1'b1) ovf_pulses++;
      if (rd_valid === 1'b1) begin
         if (exp_q.size() == 0) check("rd_unexpected_qsize", 32'(exp_q.size()), 32'd1);
         else                   check("rd_data", 32'(rd_sample), exp_q.pop_front());
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int ch, input int val);
      in_valid  = 1'b1;
      in_ch     = CB'(ch);
      in_sample = SS'(val);
      tick();
      in_valid  = 1'b0;
   endtask

   // Write frames 0..nframes-1, channels in order, value base + frame*2 + ch.
   task automatic fill(input int base, input int nframes);
      for (int f = 0; f < nframes; f++)
         for (int c = 0; c < NC; c++)
            wr(c, base + f * 2 + c);
   endtask

   task automatic rd(input int f, input int c, input int e);
      rd_en    = 1'b1;
      rd_frame = PB'(f);
      rd_ch    = CB'(c);
      exp_q.push_back(32'(e));
      last_rd  = 32'(e);
      tick();
      rd_en    = 1'b0;
   endtask

   task automatic drain(input string tag);
      tick();
      check(tag, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_ch = '0; in_sample = '0;
      rd_en = 1'b0; rd_frame = '0; rd_ch = '0; blk_done = 1'b0;
`ifdef PINGPONG_OVF_COUNT_EN
      sat_in_valid = 1'b0; sat_in_ch = 1'b0; sat_in_sample = 8'h5A;
`endif
      repeat (3) tick();
      rst = 1'b0;

      // Reset state.
      check("rst_wr_frame",  32'(wr_frame),  0);
      check("rst_blk_ready", 32'(blk_ready), 0);
      check("rst_blk_bank",  32'(blk_bank),  0);
      check("rst_rd_valid",  32'(rd_valid),  0);
      check("rst_rd_sample", 32'(rd_sample), 0);
      check("rst_overflow",  32'(overflow),  0);
      check("rst_ovf_count", 32'(ovf_count), 0);

      // Read while IDLE is ignored.
      rd_en = 1'b1; rd_frame = PB'(10); rd_ch = CB'(1);
      tick();
      rd_en = 1'b0;
      check("idle_rd_valid",  32'(rd_valid),  0);
      check("idle_rd_sample", 32'(rd_sample), 0);

      // Out-of-range channels are dropped; a non-final channel does not close a frame.
      wr(2, 'h555);
      check("bad_ch2_wr_frame", 32'(wr_frame), 0);
      wr(3, 'h666);
      check("bad_ch3_wr_frame", 32'(wr_frame), 0);
      wr(0, 'h999);
      check("ch0_only_wr_frame", 32'(wr_frame), 0);

      // First block into bank 0.
      fill(0, 63);
      check("b1_wr_frame_63", 32'(wr_frame), 63);
      wr(0, 126);
      check("b1_not_ready_yet", 32'(blk_ready), 0);
      wr(1, 127);
      check("b1_blk_ready", 32'(blk_ready), 1);
      check("b1_blk_bank",  32'(blk_bank),  0);
      check("b1_wr_frame",  32'(wr_frame),  0);
      check("b1_overflow",  32'(overflow),  0);

      // Back-to-back reads including an out-of-range channel.
      rd(10, 1, 21);
      rd(0, 0, 0);
      rd(63, 1, 127);
      rd(5, 0, 10);
      rd(10, 2, 0);
      rd(31, 1, 63);
      drain("b1_drain");

      // Consumer too slow: second block overflows and is dropped.
      fill(1000, 63);
      wr(0, 1126);
      check("ov_pre_overflow", 32'(overflow), 0);
      wr(1, 1127);
      check("ov_overflow",  32'(overflow),  1);
      check("ov_ovf_count", 32'(ovf_count), OVF_EN ? 32'd1 : 32'd0);
      check("ov_blk_bank",  32'(blk_bank),  0);
      check("ov_blk_ready", 32'(blk_ready), 1);
      check("ov_wr_frame",  32'(wr_frame),  0);
      tick();
      check("ov_pulse_end", 32'(overflow),   0);
      check("ov_pulses",    32'(ovf_pulses), 1);
      rd(10, 1, 21);
      rd(62, 0, 124);
      drain("ov_drain");

      // Release coinciding with completion: swap, no overflow.
      fill(2000, 63);
      wr(0, 2126);
      blk_done = 1'b1;
      wr(1, 2127);
      blk_done = 1'b0;
      check("rel_overflow",  32'(overflow),  0);
      check("rel_blk_ready", 32'(blk_ready), 1);
      check("rel_blk_bank",  32'(blk_bank),  1);
      check("rel_ovf_count", 32'(ovf_count), OVF_EN ? 32'd1 : 32'd0);
      tick();
      check("rel_pulses", 32'(ovf_pulses), 1);
      rd(10, 1, 2021);
      rd(63, 0, 2126);
      drain("rel_drain");

      // Plain release, then blk_done while IDLE is ignored.
      blk_done = 1'b1;
      tick();
      blk_done = 1'b0;
      check("done_blk_ready", 32'(blk_ready), 0);
      blk_done = 1'b1;
      tick();
      blk_done = 1'b0;
      check("idle_done_blk_ready", 32'(blk_ready), 0);
      check("idle_done_blk_bank",  32'(blk_bank),  1);
      rd_en = 1'b1; rd_frame = PB'(3); rd_ch = CB'(0);
      tick();
      rd_en = 1'b0;
      check("idle2_rd_valid",  32'(rd_valid),  0);
      check("idle2_rd_sample", 32'(rd_sample), last_rd);

      // Hold a block, fill 37 frames, then reset mid-operation.
      fill(3000, 64);
      check("b4_blk_ready", 32'(blk_ready), 1);
      check("b4_blk_bank",  32'(blk_bank),  0);
      fill(5000, 37);
      check("mid_wr_frame", 32'(wr_frame), 37);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mr_wr_frame",  32'(wr_frame),  0);
      check("mr_blk_ready", 32'(blk_ready), 0);
      check("mr_ovf_count", 32'(ovf_count), 0);
      check("mr_blk_bank",  32'(blk_bank),  0);

      // Next full block lands in bank 0.
      fill(4000, 64);
      check("b5_blk_ready", 32'(blk_ready), 1);
      check("b5_blk_bank",  32'(blk_bank),  0);
      rd(36, 0, 4072);
      rd(40, 1, 4081);
      rd(5, 1, 4011);
      drain("b5_drain");

`ifdef PINGPONG_OVF_COUNT_EN
      // Counter saturation: 65540 completions, the first is accepted.
      sat_in_valid = 1'b1;
      repeat (10) tick();
      check("sat_count_9", 32'(sat_ovf_count), 9);
      repeat (65530) tick();
      check("sat_count_max", 32'(sat_ovf_count), 32'hFFFF);
      check("sat_overflow",  32'(sat_overflow),  1);
      repeat (5) tick();
      sat_in_valid = 1'b0;
      check("sat_no_wrap", 32'(sat_ovf_count), 32'hFFFF);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
